// File: rtl/kogg_stone_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : kogg_stone_sub_pipe
//  Purpose  : Streaming Kogge-Stone add/subtract, one register per prefix level,
//             valid/ready on both sides, carry/borrow and signed-overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module kogg_stone_sub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    // Stage index 0 is the input register; 1..LEVELS are the prefix levels.
    logic [WIDTH-1:0] h_d [0:LEVELS];
    logic [WIDTH-1:0] h_q [0:LEVELS];
    logic [WIDTH-1:0] g_d [0:LEVELS];
    logic [WIDTH-1:0] g_q [0:LEVELS];
    logic [WIDTH-1:0] p_d [0:LEVELS-1];
    logic [WIDTH-1:0] p_q [0:LEVELS-1];
    logic [LEVELS:0]  cin_d, cin_q;
    logic [LEVELS:0]  vld_d, vld_q;

    logic             en;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] g_shf;
    logic [WIDTH-1:0] p_shf;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] d_d, d_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        en      = !out_valid_q || out_ready;
        bb      = b ^ {WIDTH{sub}};
        g_shf   = '0;
        p_shf   = '0;
        lo_mask = '0;

        h_d[0]    = a ^ bb;
        g_d[0]    = a & bb;
        // Carry-in folded into bit 0 so the prefix tree needs no separate cin term.
        g_d[0][0] = (a[0] & bb[0]) | ((a[0] | bb[0]) & sub);
        p_d[0]    = a | bb;
        cin_d[0]  = sub;
        vld_d[0]  = in_valid && en;

        // Shifting by the level distance leaves zeros below it, so those bits pass through.
        for (int k = 1; k <= LEVELS; k++) begin
            g_shf    = g_q[k-1] << (1 << (k - 1));
            g_d[k]   = g_q[k-1] | (p_q[k-1] & g_shf);
            h_d[k]   = h_q[k-1];
            cin_d[k] = cin_q[k-1];
            vld_d[k] = vld_q[k-1];
        end

        for (int k = 1; k < LEVELS; k++) begin
            lo_mask = ~({WIDTH{1'b1}} << (1 << (k - 1)));
            p_shf   = p_q[k-1] << (1 << (k - 1));
            p_d[k]  = p_q[k-1] & (p_shf | lo_mask);
        end

        carry       = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};
        d_d         = h_q[LEVELS] ^ carry;
        cout_d      = g_q[LEVELS][WIDTH-1];
        ovf_d       = carry[WIDTH-1] ^ g_q[LEVELS][WIDTH-1];
        out_valid_d = vld_q[LEVELS];
    end

    // Single global enable: the whole pipe freezes while the output is blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= LEVELS; k++) begin
                h_q[k] <= '0;
                g_q[k] <= '0;
            end
            for (int k = 0; k < LEVELS; k++) begin
                p_q[k] <= '0;
            end
            cin_q       <= '0;
            vld_q       <= '0;
            d_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k <= LEVELS; k++) begin
                h_q[k] <= h_d[k];
                g_q[k] <= g_d[k];
            end
            for (int k = 0; k < LEVELS; k++) begin
                p_q[k] <= p_d[k];
            end
            cin_q       <= cin_d;
            vld_q       <= vld_d;
            d_q         <= d_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/kogg_stone_sub_pipe.md
Name: kogg_stone_sub_pipe

Overview:
- Pipelined parallel-prefix (Kogge-Stone) add/subtract unit with valid/ready handshakes on both sides.
- Computes a-b (or a+b) as a + (b XOR {W{sub}}) + sub.
- Each prefix level is registered. Provides carry/borrow and signed-overflow flags.
- Used wherever datapaths need a registered, streaming subtractor rather than a combinational adder.

Parameters:
- WIDTH, 8, operand width; must be a power of two, at least 2.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  minuend / addend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  1 = a-b, 0 = a+b.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits clear to 0.
  - out_valid=0, d=0, cout=0, ovf=0.
  - Data registers clear to 0.
  - in_ready=1 after release.
- Pipeline enable: en = !out_valid | out_ready. This is a global stall; no bubble collapsing. in_ready = en.
- Stage 0 (input register), on en:
  - Capture bb = b ^ {WIDTH{sub}} and cin = sub.
  - Form per-bit h = a^bb, g = a&bb, p = a|bb.
  - Fold the carry-in into bit 0: g[0] = (a[0]&bb[0]) | ((a[0]|bb[0]) & cin).
  - Register h, g, p, cin, a[MSB]^bb[MSB], and valid = in_valid & in_ready.
- Stages 1..LEVELS (prefix), on en, level k with distance 2^(k-1):
  - For i >= dist: G' = G[i] | (P[i] & G[i-dist]) and P' = P[i] & P[i-dist].
  - For i < dist: pass G and P through unchanged.
  - h, cin, and valid are carried forward.
- Final stage (sum), on en:
  - Carries: c[0] = cin, c[i] = G[i-1] for i = 1..WIDTH-1.
  - d = h ^ c, cout = G[WIDTH-1], ovf = c[WIDTH-1] ^ G[WIDTH-1].
  - out_valid = valid.
- Latency: LEVELS+2 enabled cycles from input handshake to out_valid (5 for WIDTH=8).
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, every stage holds its value and in_ready=0. No beat is lost or duplicated.
- Bubbles: invalid beats propagate as bubbles. Data registers in bubble stages may update, but valid=0 marks them.
- Simultaneous events: in_valid and a draining out_ready in the same cycle → both handshakes complete and the pipeline advances.
- in_valid while in_ready=0: the beat is not taken; a, b, and sub must be held by the producer.
- Reset mid-operation: all in-flight beats are discarded; no spurious out_valid after release.
- Width rules:
  - d wraps modulo 2^WIDTH.
  - Sub mode: cout is the inverted borrow.
  - Add mode: cout is the unsigned carry.
- Results must match exact integer arithmetic for all 2^(2·WIDTH+1) input combinations at WIDTH=8.

Test Plan:
- Subtract, a=8'h05, b=8'h03, sub=1, out_ready=1 → after 5 cycles: d=8'h02, cout=1, ovf=0.
- Borrow, a=8'h00, b=8'h01, sub=1 → d=8'hFF, cout=0, ovf=0.
- Signed overflow:
  - Add a=8'h7F, b=8'h01, sub=0 → d=8'h80, cout=0, ovf=1.
  - Subtract a=8'h80, b=8'h01, sub=1 → d=8'h7F, cout=1, ovf=1.
- Back-to-back with backpressure:
  - Stimulus: 10 consecutive random beats; out_ready held 0 for 3 cycles mid-stream.
  - Response: results in order, matching a scoreboard. in_ready=0 exactly while out_valid=1 and out_ready=0. No drops or duplicates.
- Reset mid-flight: assert reset=0 asynchronously with 3 beats in flight → out_valid=0 immediately. No outputs appear after release until new inputs are accepted.
- Exhaustive at WIDTH=8: all a, b, sub with out_ready=1 → d, cout, and ovf match reference arithmetic every cycle.
